dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: data-memory word address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive denied io cycles that force an io grant; legal range 1..15.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  memory-stage access request (lw or sw).
REQ-007 cpu_wren  input  1  1 = store, 0 = load; sampled with cpu_req.
REQ-008 cpu_addr  input  ADDR_W  word address (ALU result low bits).
REQ-009 cpu_wdata  input  DATA_W  store data.
REQ-010 cpu_gnt  output  1  cpu access issued to memory this cycle.
REQ-011 cpu_stall  output  1  cpu_req & ~cpu_gnt; holds the processor pipeline.
REQ-012 cpu_rvalid  output  1  load data for the cpu valid on cpu_rdata this cycle.
REQ-013 cpu_rdata  output  DATA_W  load return data.
REQ-014 io_req, io_wren, io_addr, io_wdata  input  1/1/ADDR_W/DATA_W  game-logic/display port, same meaning as cpu_*.
REQ-015 io_gnt, io_rvalid, io_rdata  output  1/1/DATA_W  same meaning as cpu_*.
REQ-016 address_dmem  output  ADDR_W  memory address.
REQ-017 d_dmem  output  DATA_W  memory write data.
REQ-018 wren  output  1  memory write enable.
REQ-019 q_dmem  input  DATA_W  memory read data, valid one cycle after address presented.

Function
REQ-020 At most one of cpu_gnt, io_gnt SHALL be 1 in any cycle; grants are combinational from current requests and registered state.
REQ-021 Default priority SHALL be cpu: cpu_gnt = cpu_req unless force_io is set.
REQ-022 io_gnt SHALL be 1 when io_req and (~cpu_req or force_io).
REQ-023 starve_cnt (4 bits) SHALL increment each cycle io_req=1 and io_gnt=0, saturating at 15; SHALL clear on any cycle io_gnt=1 or io_req=0.
REQ-024 force_io SHALL be combinational: io_req and starve_cnt >= STARVE_LIMIT.
REQ-025 Memory outputs SHALL mux from the granted port: address_dmem, d_dmem, wren = granted port's addr, wdata, wren; with no grant, address_dmem = 0, d_dmem = 0, wren = 0.
REQ-026 wren SHALL never be 1 without a grant.
REQ-027 A granted load SHALL set a registered pending flag and owner tag; next cycle the owner's rvalid = 1 and its rdata = q_dmem; the other port's rvalid = 0.
REQ-028 Store grants SHALL NOT produce rvalid.
REQ-029 Read latency from grant to rvalid SHALL be exactly 1 cycle; back-to-back loads, including alternating owners, SHALL sustain one per cycle.
REQ-030 cpu_rdata and io_rdata SHALL be 0 whenever their rvalid is 0.
REQ-031 A requester SHALL hold req/wren/addr/wdata stable until granted; the arbiter does not latch ungranted requests.
REQ-032 Same-cycle cpu store and io load to the same address: cpu SHALL win (unless force_io); io load issued later SHALL return the stored value.

Reset
REQ-033 While resetn=0: starve_cnt = 0, pending = 0, owner = cpu; cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, wren = 0; address_dmem, d_dmem, rdata outputs = 0, regardless of req inputs.
REQ-034 Reset asserted with a load pending SHALL discard it: no rvalid after resetn deasserts.
REQ-035 First cycle after resetn rises SHALL arbitrate normally from the reset state.

Verification
REQ-036 cpu_req load addr 0x010 alone, mem[0x010]=0xDEADBEEF -> cpu_gnt same cycle, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, io_rvalid=0.
REQ-037 cpu_req and io_req held high continuously, STARVE_LIMIT=4 -> io denied 4 cycles, io_gnt=1 and cpu_stall=1 on 5th, cpu_gnt next cycle, pattern repeats every 5 cycles.
REQ-038 Same cycle cpu store 0x00000055 to 0x020 and io load 0x020 -> cpu_gnt, wren=1; io granted next cycle, io_rdata=0x00000055 one cycle later.
REQ-039 Alternating cpu load 0x001 / io load 0x002 every cycle -> rvalid toggles owner each cycle with correct data, no gap cycles.
REQ-040 resetn pulled low the cycle after an io load grant -> io_rvalid never asserts; all outputs 0 during reset.
REQ-041 io_req only, io store 0x0000_00FF to 0xFFF -> io_gnt=1, wren=1, address_dmem=0xFFF, d_dmem=0x000000FF; starve_cnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - cpu/io requester ports and data-memory port of the dmem arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              io_req;
  logic              io_wren;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_gnt;
  logic              io_rvalid;
  logic [DATA_W-1:0] io_rdata;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] d_dmem;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  io_req, io_wren, io_addr, io_wdata,
    input  q_dmem,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output io_gnt, io_rvalid, io_rdata,
    output address_dmem, d_dmem, wren
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output io_req, io_wren, io_addr, io_wdata,
    output q_dmem,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  address_dmem, d_dmem, wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - cpu-priority data-memory arbiter with io starvation guard
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           resetn,
  dmem_arbiter_if.slave bus
);
  logic [3:0] starve_cnt;
  logic       pending;
  logic       owner;  // 0 = cpu, 1 = io
  logic       force_io;
  logic       cpu_gnt;
  logic       io_gnt;
  logic       load_issued;

  // Grants are gated by resetn so outputs stay quiet while reset is held.
  assign force_io    = bus.io_req && (starve_cnt >= 4'(STARVE_LIMIT));
  assign cpu_gnt     = resetn && bus.cpu_req && !force_io;
  assign io_gnt      = resetn && bus.io_req && (!bus.cpu_req || force_io);
  assign load_issued = (cpu_gnt && !bus.cpu_wren) || (io_gnt && !bus.io_wren);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 4'd0;
      pending    <= 1'b0;
      owner      <= 1'b0;
    end else begin
      if (bus.io_req && !io_gnt) begin
        if (starve_cnt != 4'd15) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
      pending <= load_issued;
      owner   <= io_gnt;
    end
  end

  always_comb begin
    bus.cpu_gnt      = cpu_gnt;
    bus.io_gnt       = io_gnt;
    bus.cpu_stall    = resetn && bus.cpu_req && !cpu_gnt;
    bus.address_dmem = '0;
    bus.d_dmem       = '0;
    bus.wren         = 1'b0;
    if (cpu_gnt) begin
      bus.address_dmem = bus.cpu_addr;
      bus.d_dmem       = bus.cpu_wdata;
      bus.wren         = bus.cpu_wren;
    end else if (io_gnt) begin
      bus.address_dmem = bus.io_addr;
      bus.d_dmem       = bus.io_wdata;
      bus.wren         = bus.io_wren;
    end
    bus.cpu_rvalid = pending && !owner;
    bus.io_rvalid  = pending && owner;
    bus.cpu_rdata  = (pending && !owner) ? bus.q_dmem : '0;
    bus.io_rdata   = (pending && owner) ? bus.q_dmem : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a reference memory model
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory attached to the arbiter: one-cycle registered read.
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (bus.wren) mem[bus.address_dmem] = bus.d_dmem;
    bus.q_dmem = mem[bus.address_dmem];
  end

  typedef struct {
    int                due;
    bit                owner;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: io wins once it has waited LIMIT cycles, otherwise cpu wins.
  int waited = 0;
  bit exp_cpu_gnt = 0;
  bit exp_io_gnt  = 0;
  always @(negedge clock) begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    bit                ew;
    if (!resetn) begin
      exp_cpu_gnt = 0;
      exp_io_gnt  = 0;
      waited      = 0;
      sb.delete();
      chk("rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("rst_io_gnt", bus.io_gnt, 0);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_wren", bus.wren, 0);
      chk("rst_addr", bus.address_dmem, 0);
      chk("rst_d", bus.d_dmem, 0);
    end else begin
      exp_io_gnt  = bus.io_req && (!bus.cpu_req || waited >= LIMIT);
      exp_cpu_gnt = bus.cpu_req && !exp_io_gnt;
      chk("cpu_gnt", bus.cpu_gnt, exp_cpu_gnt);
      chk("io_gnt", bus.io_gnt, exp_io_gnt);
      chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !exp_cpu_gnt);
      ea = '0; ed = '0; ew = 0;
      if (exp_cpu_gnt) begin ea = bus.cpu_addr; ed = bus.cpu_wdata; ew = bus.cpu_wren; end
      if (exp_io_gnt)  begin ea = bus.io_addr;  ed = bus.io_wdata;  ew = bus.io_wren;  end
      chk("wren", bus.wren, ew);
      chk("address_dmem", bus.address_dmem, ea);
      chk("d_dmem", bus.d_dmem, ed);
      if ((exp_cpu_gnt || exp_io_gnt) && !ew) sb.push_back('{cyc + 1, exp_io_gnt, ref_mem[ea]});
      if ((exp_cpu_gnt || exp_io_gnt) && ew) ref_mem[ea] = ed;
      if (bus.io_req && !exp_io_gnt) waited = (waited < 15) ? waited + 1 : 15;
      else waited = 0;
    end
  end

  // Read-return monitor
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      chk("rst_io_rvalid", bus.io_rvalid, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_io_rdata", bus.io_rdata, 0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("cpu_rvalid", bus.cpu_rvalid, !e.owner);
      chk("io_rvalid", bus.io_rvalid, e.owner);
      chk("rdata", e.owner ? bus.io_rdata : bus.cpu_rdata, e.data);
      chk("idle_rdata", e.owner ? bus.cpu_rdata : bus.io_rdata, 0);
    end else begin
      chk("no_rvalid", {bus.cpu_rvalid, bus.io_rvalid}, 0);
      chk("zero_rdata", {bus.cpu_rdata, bus.io_rdata}, 0);
    end
  end

  task automatic drive(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                       input bit ir, input bit iw, input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] id);
    @(posedge clock);
    #1;
    bus.cpu_req = cr; bus.cpu_wren = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.io_req  = ir; bus.io_wren  = iw; bus.io_addr  = ia; bus.io_wdata  = id;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    bit                cr, cw, ir, iw;
    logic [ADDR_W-1:0] ca, ia;
    logic [DATA_W-1:0] cd, id;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem[a] = $urandom;
      ref_mem[a] = mem[a];
    end
    mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
    bus.q_dmem = '0;
    // Requests asserted during reset must not leak out.
    bus.cpu_req = 1; bus.cpu_wren = 1; bus.cpu_addr = 12'h123; bus.cpu_wdata = 32'h1;
    bus.io_req  = 1; bus.io_wren  = 1; bus.io_addr  = 12'h321; bus.io_wdata  = 32'h2;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1;
    bus.cpu_req = 0; bus.io_req = 0; bus.cpu_wren = 0; bus.io_wren = 0;

    // Single cpu load
    drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
    idle(2);

    // Continuous contention: io forced every 5th cycle
    for (int k = 0; k < 15; k++) drive(1, 0, 12'(k), '0, 1, 0, 12'h100, '0);
    idle(2);

    // Same-cycle cpu store / io load to one address
    drive(1, 1, 12'h020, 32'h55, 1, 0, 12'h020, '0);
    drive(0, 0, '0, '0, 1, 0, 12'h020, '0);
    idle(2);

    // Alternating owners, back-to-back loads
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drive(1, 0, 12'h001, '0, 0, 0, '0, '0);
      else            drive(0, 0, '0, '0, 1, 0, 12'h002, '0);
    end
    idle(2);

    // Reset the cycle after an io load grant
    drive(0, 0, '0, '0, 1, 0, 12'h030, '0);
    @(posedge clock);
    #1;
    resetn = 0;
    bus.cpu_req = 1; bus.io_req = 1;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1;
    bus.cpu_req = 0; bus.io_req = 0;
    idle(3);

    // io store at the top address
    drive(0, 0, '0, '0, 1, 1, 12'hFFF, 32'h000000FF);
    idle(1);
    drive(0, 0, '0, '0, 1, 0, 12'hFFF, '0);
    idle(2);

    // Randomized traffic; each port holds its request until the model grants it.
    cr = 0; cw = 0; ca = '0; cd = '0; ir = 0; iw = 0; ia = '0; id = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      #1;
      if (!cr || exp_cpu_gnt) begin
        cr = ($urandom_range(0, 9) < 7); cw = $urandom_range(0, 1);
        ca = 12'($urandom_range(0, 15)); cd = $urandom;
      end
      if (!ir || exp_io_gnt) begin
        ir = ($urandom_range(0, 9) < 6); iw = $urandom_range(0, 1);
        ia = 12'($urandom_range(0, 15)); id = $urandom;
      end
      drive(cr, cw, ca, cd, ir, iw, ia, id);
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
